// File: rtl/countdown_timer_pkg.sv
// Shared timer package: state encoding for the countdown timer and timebase counters.
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } timer_state_t;

endpackage

// File: rtl/countdown_timer.sv
// Tick-driven countdown timer with IDLE/RUN/PAUSE/DONE control and a one-cycle expiry pulse.
// Optional feature: define COUNTDOWN_TIMER_AUTO_RELOAD_EN to restart from the loaded value on expiry.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic             start,
  input  logic             stop,
  output logic [WIDTH-1:0] count_out,
  output logic             running,
  output logic             done,
  output logic             expired
);

  timer_state_t     r_state;
  timer_state_t     w_state_nxt;
  logic [WIDTH-1:0] r_count;
  logic [WIDTH-1:0] w_count_nxt;
  logic             w_expire;
  logic             w_running_nxt;
  logic             w_done_nxt;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
  logic [WIDTH-1:0] r_reload;
`endif

  // State register plus registered outputs; active-low reset overrides every strobe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
      r_count <= '0;
      running <= 1'b0;
      done    <= 1'b0;
      expired <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_count <= w_count_nxt;
      running <= w_running_nxt;
      done    <= w_done_nxt;
      expired <= w_expire;
    end
  end

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
  // Reload value captured alongside every load.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_reload <= '0;
    end else if (load) begin
      r_reload <= load_value;
    end else begin
      r_reload <= r_reload;
    end
  end
`endif

  // Next-state and count logic; load beats everything, stop beats start and tick.
  always_comb begin
    w_state_nxt = r_state;
    w_count_nxt = r_count;
    w_expire    = 1'b0;
    if (load) begin
      w_state_nxt = ST_IDLE;
      w_count_nxt = load_value;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start && !stop && (r_count != '0)) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (stop) begin
            w_state_nxt = ST_PAUSE;
          end else if (tick && (r_count == WIDTH'(1))) begin
            w_expire = 1'b1;
`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
            w_count_nxt = r_reload;
            w_state_nxt = (r_reload == '0) ? ST_DONE : ST_RUN;
`else
            w_count_nxt = '0;
            w_state_nxt = ST_DONE;
`endif
          end else if (tick && (r_count != '0)) begin
            w_count_nxt = r_count - WIDTH'(1);
          end else begin
            w_count_nxt = r_count;
          end
        end
        ST_PAUSE: begin
          if (start && !stop) begin
            w_state_nxt = ST_RUN;
          end else begin
            w_state_nxt = ST_PAUSE;
          end
        end
        ST_DONE: begin
          w_state_nxt = ST_DONE;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_count_nxt = '0;
        end
      endcase
    end
  end

  // Output decode of the next state, registered above so outputs never see inputs combinationally.
  always_comb begin
    w_running_nxt = 1'b0;
    w_done_nxt    = 1'b0;
    case (w_state_nxt)
      ST_RUN:  w_running_nxt = 1'b1;
      ST_DONE: w_done_nxt    = 1'b1;
      default: begin
        w_running_nxt = 1'b0;
        w_done_nxt    = 1'b0;
      end
    endcase
  end

  assign count_out = r_count;

endmodule

// File: tb/tb_countdown_timer.sv
// Directed self-checking bench for countdown_timer; the auto-reload scenario runs only
// when COUNTDOWN_TIMER_AUTO_RELOAD_EN is defined.
module tb_countdown_timer;

  localparam int WIDTH = 16;

  logic             clk;
  logic             rst;
  logic             tick;
  logic             load;
  logic [WIDTH-1:0] load_value;
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] count_out;
  logic             running;
  logic             done;
  logic             expired;

  int n_tests;
  int n_fail;
  int n_exp;

  countdown_timer #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .tick       (tick),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .stop       (stop),
    .count_out  (count_out),
    .running    (running),
    .done       (done),
    .expired    (expired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  // One clock; outputs sampled 1 time unit after the edge, expiry pulses tallied.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (expired === 1'b1) n_exp++;
  endtask

  // Apply a one-cycle strobe combination, then release all strobes.
  task automatic pulse(input logic l, input logic [WIDTH-1:0] v, input logic s,
                       input logic p, input logic t);
    load = l; load_value = v; start = s; stop = p; tick = t;
    cyc();
    load = 1'b0; start = 1'b0; stop = 1'b0; tick = 1'b0;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) cyc();
  endtask

  initial begin
    n_tests = 0; n_fail = 0; n_exp = 0;
    rst = 1'b0; tick = 1'b0; load = 1'b0; load_value = '0; start = 1'b0; stop = 1'b0;
    cyc(); cyc();
    check("rst_count", 32'(count_out), 32'd0);
    check("rst_running", 32'(running), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_expired", 32'(expired), 32'd0);
    rst = 1'b1;
    cyc();

    // Load 3, start, three ticks spaced five cycles apart.
    n_exp = 0;
    pulse(1'b1, 16'd3, 1'b0, 1'b0, 1'b0);
    check("t1_load", 32'(count_out), 32'd3);
    check("t1_idle_running", 32'(running), 32'd0);
    pulse(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    check("t1_start_running", 32'(running), 32'd1);
    for (int i = 1; i <= 3; i++) begin
      idle(4);
      check("t1_no_tick_hold", 32'(count_out), 32'(3 - i + 1));
      pulse(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
      check("t1_count", 32'(count_out), 32'(3 - i));
      check("t1_expired", 32'(expired), (i == 3) ? 32'd1 : 32'd0);
    end
    check("t1_done", 32'(done), 32'd1);
    check("t1_running", 32'(running), 32'd0);
    cyc();
    check("t1_expired_drop", 32'(expired), 32'd0);
    pulse(1'b0, 16'd0, 1'b1, 1'b0, 1'b1);
    pulse(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
    check("t1_done_hold", 32'(done), 32'd1);
    check("t1_done_count", 32'(count_out), 32'd0);
    check("t1_exp_total", 32'(n_exp), 32'd1);

    // Load 5, two ticks, pause through three ticks, resume to expiry.
    n_exp = 0;
    pulse(1'b1, 16'd5, 1'b0, 1'b0, 1'b0);
    check("t2_done_cleared", 32'(done), 32'd0);
    pulse(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 16'd0, 1'b0, 1'b0, 1'b1); idle(2);
    pulse(1'b0, 16'd0, 1'b0, 1'b0, 1'b1); idle(2);
    check("t2_before_stop", 32'(count_out), 32'd3);
    pulse(1'b0, 16'd0, 1'b0, 1'b1, 1'b0);
    check("t2_pause_running", 32'(running), 32'd0);
    for (int i = 0; i < 3; i++) begin
      pulse(1'b0, 16'd0, 1'b0, 1'b0, 1'b1); idle(1);
    end
    check("t2_pause_hold", 32'(count_out), 32'd3);
    pulse(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    check("t2_resume", 32'(running), 32'd1);
    for (int i = 0; i < 3; i++) begin
      pulse(1'b0, 16'd0, 1'b0, 1'b0, 1'b1); idle(2);
    end
    check("t2_final_count", 32'(count_out), 32'd0);
    check("t2_final_done", 32'(done), 32'd1);
    check("t2_exp_total", 32'(n_exp), 32'd1);

    // Load 4, start, then stop and tick together; also start+stop in RUN.
    pulse(1'b1, 16'd4, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 16'd0, 1'b0, 1'b1, 1'b1);
    check("t3_count_held", 32'(count_out), 32'd4);
    check("t3_paused_running", 32'(running), 32'd0);
    check("t3_paused_done", 32'(done), 32'd0);
    pulse(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
    check("t3_pause_start_stop", 32'(running), 32'd0);
    pulse(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    check("t3_resume", 32'(running), 32'd1);
    pulse(1'b0, 16'd0, 1'b1, 1'b1, 1'b0);
    check("t3_run_start_stop", 32'(running), 32'd0);
    pulse(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
    check("t3_count_after", 32'(count_out), 32'd4);

    // Load 0 then start is ignored; load with start lands in IDLE.
    n_exp = 0;
    pulse(1'b1, 16'd0, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    idle(2);
    check("t4_zero_running", 32'(running), 32'd0);
    check("t4_zero_done", 32'(done), 32'd0);
    check("t4_zero_exp", 32'(n_exp), 32'd0);
    pulse(1'b1, 16'd2, 1'b1, 1'b0, 1'b0);
    check("t4_ld_start_running", 32'(running), 32'd0);
    check("t4_ld_start_count", 32'(count_out), 32'd2);
    pulse(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
    check("t4_idle_tick", 32'(count_out), 32'd2);

    // Load 6, two ticks, then a one-cycle reset with competing strobes.
    n_exp = 0;
    pulse(1'b1, 16'd6, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
    pulse(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
    check("t5_pre_reset", 32'(count_out), 32'd4);
    rst = 1'b0;
    pulse(1'b1, 16'd9, 1'b1, 1'b0, 1'b1);
    rst = 1'b1;
    check("t5_rst_count", 32'(count_out), 32'd0);
    check("t5_rst_running", 32'(running), 32'd0);
    check("t5_rst_done", 32'(done), 32'd0);
    check("t5_rst_expired", 32'(expired), 32'd0);
    for (int i = 0; i < 3; i++) pulse(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
    pulse(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
    check("t5_post_count", 32'(count_out), 32'd0);
    check("t5_post_running", 32'(running), 32'd0);
    check("t5_exp_total", 32'(n_exp), 32'd0);

`ifdef COUNTDOWN_TIMER_AUTO_RELOAD_EN
    // Load 2, start, six ticks: expiry after every second tick, reloading to 2.
    n_exp = 0;
    pulse(1'b1, 16'd2, 1'b0, 1'b0, 1'b0);
    pulse(1'b0, 16'd0, 1'b1, 1'b0, 1'b0);
    for (int i = 1; i <= 6; i++) begin
      pulse(1'b0, 16'd0, 1'b0, 1'b0, 1'b1);
      check("t6_expired", 32'(expired), (i % 2 == 0) ? 32'd1 : 32'd0);
      check("t6_count", 32'(count_out), (i % 2 == 0) ? 32'd2 : 32'd1);
      check("t6_running", 32'(running), 32'd1);
      idle(1);
    end
    check("t6_exp_total", 32'(n_exp), 32'd3);
    check("t6_done", 32'(done), 32'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/countdown_timer.md
COUNTDOWN_TIMER -- requirements
Module: countdown_timer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, giving the countdown value width in bits.
REQ-002 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-003 SHALL have port rst, input, 1, the reset; it is synchronous and active-low.
REQ-004 SHALL have port tick, input, 1, a one-cycle timebase pulse from the external timer chain (e.g. the 100 ms pulse).
REQ-005 SHALL have port load, input, 1, a one-cycle strobe that captures load_value.
REQ-006 SHALL have port load_value, input, WIDTH, the start value of the countdown.
REQ-007 SHALL have port start, input, 1, a one-cycle strobe that starts or resumes the countdown.
REQ-008 SHALL have port stop, input, 1, a one-cycle strobe that pauses the countdown.
REQ-009 SHALL have port count_out, output, WIDTH, the remaining tick count (registered).
REQ-010 SHALL have port running, output, 1, high while in RUN.
REQ-011 SHALL have port done, output, 1, high while in DONE.
REQ-012 SHALL have port expired, output, 1, a one-cycle pulse on reaching zero.

Function
REQ-013 SHALL implement states IDLE, RUN, PAUSE and DONE.
REQ-014 SHALL act on load in any state: count <= load_value, reload register <= load_value, state -> IDLE, expired = 0 next cycle.
  - load has priority over start, stop and tick in the same cycle.
REQ-015 SHALL handle start in IDLE:
  - count != 0: go to RUN next cycle.
  - count == 0: ignore start and stay in IDLE.
REQ-016 SHALL, in RUN, decrement count by 1 per cycle with tick = 1.
  - count_out shows the new value one cycle after the tick.
  - No change on cycles without tick.
REQ-017 SHALL, in RUN with tick and count == 1:
  - set count to 0 and enter DONE.
  - assert expired for exactly the next cycle, aligned with count_out == 0.
REQ-018 SHALL handle stop/start between RUN and PAUSE:
  - stop in RUN: enter PAUSE and hold count.
  - start in PAUSE: return to RUN.
  - Ticks are ignored in PAUSE, IDLE and DONE.
REQ-019 SHALL let stop win when stop and tick are both high in RUN: tick not counted, count held.
REQ-020 SHALL let stop win when start and stop are both high: RUN -> PAUSE; IDLE/PAUSE unchanged.
REQ-021 SHALL hold DONE until load (without AUTO_RELOAD_EN); start and stop are ignored in DONE.
REQ-022 SHALL keep count arithmetic in WIDTH bits with no wrap below 0.
  - Decrement happens only when count >= 1.
REQ-023 SHALL drive running and done as registered decodes of state (no combinational input-to-output paths).

Reset
REQ-024 SHALL, with rst = 0 at a rising clk edge, set:
  - state = IDLE
  - count_out = 0 and reload register = 0
  - running = 0, done = 0, expired = 0
REQ-025 SHALL let reset mid-operation (any state) abort immediately with no expired pulse.
  - rst = 0 overrides load, start, stop and tick.

Configuration
REQ-026 SHALL support macro COUNTDOWN_TIMER_AUTO_RELOAD_EN.
  - Defined: at the REQ-017 expiry, count <= reload register and state stays RUN; expired still pulses one cycle; DONE is unreachable unless the reload register = 0, which enters DONE.
  - Undefined: behaviour per REQ-017/REQ-021; the reload register may be omitted.

Structure
REQ-027 SHALL place the state encoding (2-bit IDLE=0, RUN=1, PAUSE=2, DONE=3) in the shared timer package.
  - Shared with the timebase counters.
REQ-028 SHALL be a single module with no sub-module; the tick source is instantiated externally by the integrator.

Verification
REQ-029 SHALL check: reset, then load 3, start, 3 ticks spaced 5 cycles apart -> count_out 3,2,1,0; expired one cycle with count 0; done = 1, running = 0.
REQ-030 SHALL check: load 5, start, 2 ticks, stop, 3 ticks, start, 3 ticks -> count 3 held through PAUSE, then expires; exactly 1 expired pulse.
REQ-031 SHALL check: load 4, start, stop and tick in the same cycle -> count stays 4, state PAUSE.
REQ-032 SHALL check: load 0, start -> stays IDLE, running = 0, no expired; load 2 together with start -> IDLE, count 2.
REQ-033 SHALL check: load 6, start, 2 ticks, rst = 0 for one cycle -> all outputs 0, IDLE; following ticks leave count at 0.
REQ-034 SHALL check, with COUNTDOWN_TIMER_AUTO_RELOAD_EN: load 2, start, 6 ticks -> expired after ticks 2, 4 and 6; count_out returns to 2 each time; running stays 1.
